// File: rtl/field_scanout.sv
// Raster reader: snapshots the 20x20 occupancy field in vertical blanking and scans it out as VGA-style video.
// Optional build macro SCAN_GRID_EN draws a green grid over empty field cells.
module field_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CELL_PX  = 16,
    parameter int X0       = 160,
    parameter int Y0       = 80
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pix_ce,
    input  logic [399:0] field_in,
    output logic         hsync,
    output logic         vsync,
    output logic         de,
    output logic [2:0]   rgb,
    output logic         snap_done
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int CW      = ((HW > VW) ? HW : VW) + 3;
    localparam int CELL_SH = $clog2(CELL_PX);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic signed [CW-1:0] X0_S   = CW'(X0);
    localparam logic signed [CW-1:0] Y0_S   = CW'(Y0);
    localparam logic signed [CW-1:0] FLD_HI = CW'(20 * CELL_PX);
    localparam logic signed [CW-1:0] BRD_LO = CW'(-CELL_PX);
    localparam logic signed [CW-1:0] BRD_HI = CW'(21 * CELL_PX);

    logic [HW-1:0]        h_cnt;
    logic [VW-1:0]        v_cnt;
    logic [399:0]         snap;

    logic                 hsync_p0, vsync_p0, de_p0, capture_p0;
    logic [2:0]           rgb_p0;
    logic signed [CW-1:0] dx_p0, dy_p0;
    logic                 in_fx_p0, in_fy_p0, in_bx_p0, in_by_p0;
    logic [4:0]           col_p0, row_p0;
    logic [8:0]           cell_idx_p0;

    // stage p0: decode the current counter position
    assign hsync_p0   = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    assign vsync_p0   = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    assign de_p0      = (h_cnt < H_ACT_L) && (v_cnt < V_ACT_L);
    assign capture_p0 = (h_cnt == '0) && (v_cnt == V_ACT_L);

    // Offsets relative to the field origin; negative values lie left of / above it.
    assign dx_p0 = $signed(CW'(h_cnt)) - X0_S;
    assign dy_p0 = $signed(CW'(v_cnt)) - Y0_S;

    assign in_fx_p0 = !dx_p0[CW-1] && (dx_p0 < FLD_HI);
    assign in_fy_p0 = !dy_p0[CW-1] && (dy_p0 < FLD_HI);
    assign in_bx_p0 = (dx_p0 >= BRD_LO) && (dx_p0 < BRD_HI);
    assign in_by_p0 = (dy_p0 >= BRD_LO) && (dy_p0 < BRD_HI);

    assign col_p0      = dx_p0[CELL_SH +: 5];
    assign row_p0      = dy_p0[CELL_SH +: 5];
    assign cell_idx_p0 = 9'(row_p0) * 9'd20 + 9'(col_p0);

    always_comb begin
        rgb_p0 = 3'b000;
        if (de_p0) begin
            if (in_fx_p0 && in_fy_p0) begin
                if (snap[cell_idx_p0]) begin
                    rgb_p0 = 3'b111;
                end
`ifdef SCAN_GRID_EN
                else if ((dx_p0[CELL_SH-1:0] == '0) || (dy_p0[CELL_SH-1:0] == '0)) begin
                    rgb_p0 = 3'b010;
                end
`endif
            end else if (in_bx_p0 && in_by_p0) begin
                rgb_p0 = 3'b001;
            end
        end
    end

    // stage p1: registered outputs, counters and snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            snap      <= '0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            de        <= 1'b0;
            rgb       <= 3'b000;
            snap_done <= 1'b0;
        end else begin
            snap_done <= 1'b0;
            if (pix_ce) begin
                hsync <= hsync_p0;
                vsync <= vsync_p0;
                de    <= de_p0;
                rgb   <= rgb_p0;
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
                // Capture only in blanking so a frame never mixes two field states.
                if (capture_p0) begin
                    snap      <= field_in;
                    snap_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_field_scanout.sv
// Self-checking bench for field_scanout on a shrunken raster (56x55 total, 2-pixel cells).
module tb_field_scanout;

    localparam int HA = 48, HFP = 2, HS = 4, HBP = 2;
    localparam int VA = 48, VFP = 2, VSY = 2, VBP = 3;
    localparam int C = 2, X0 = 4, Y0 = 4;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
`ifdef SCAN_GRID_EN
    localparam bit GRID = 1'b1;
`else
    localparam bit GRID = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pix_ce = 1'b0;
    logic [399:0] field_in = '0;
    logic         hsync, vsync, de, snap_done;
    logic [2:0]   rgb;

    field_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .CELL_PX(C), .X0(X0), .Y0(Y0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .field_in(field_in),
        .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb), .snap_done(snap_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int           mh = 0, mv = 0, frame = 0, last_h = 0, last_v = 0;
    logic [399:0] msnap = '0;
    logic         e_hs = 1'b1, e_vs = 1'b1, e_de = 1'b0, e_sd = 1'b0, ce_edge = 1'b0;
    logic [2:0]   e_rgb = 3'b000;

    logic [2:0]   pixmap [VA][HA];
    int           de_n = 0, hs_n = 0, vs_n = 0, sd_n = 0;
    int           ce_mode = 0;
    int           cyc = 0;

    function automatic logic [2:0] ref_rgb(int x, int y, logic [399:0] s);
        int fx, fy, f;
        if (x >= HA || y >= VA) return 3'b000;
        fx = x - X0;
        fy = y - Y0;
        f  = 20 * C;
        if (fx >= 0 && fx < f && fy >= 0 && fy < f) begin
            if (s[(fy / C) * 20 + fx / C]) return 3'b111;
            if (GRID && ((fx % C) == 0 || (fy % C) == 0)) return 3'b010;
            return 3'b000;
        end
        if (fx >= -C && fx < f + C && fy >= -C && fy < f + C) return 3'b001;
        return 3'b000;
    endfunction

    function automatic logic [399:0] rnd_field();
        logic [415:0] r;
        for (int i = 0; i < 13; i++) r[i*32 +: 32] = $urandom;
        return r[399:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mh = 0; mv = 0; frame = 0; msnap = '0;
            e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_rgb = 3'b000; e_sd = 1'b0; ce_edge = 1'b0;
        end else begin
            e_sd    = 1'b0;
            ce_edge = pix_ce;
            if (pix_ce) begin
                e_hs  = !(mh >= HA + HFP && mh < HA + HFP + HS);
                e_vs  = !(mv >= VA + VFP && mv < VA + VFP + VSY);
                e_de  = (mh < HA) && (mv < VA);
                e_rgb = ref_rgb(mh, mv, msnap);
                if (mh == 0 && mv == VA) begin
                    msnap = field_in;
                    e_sd  = 1'b1;
                end
                last_h = mh;
                last_v = mv;
                mh++;
                if (mh == HT) begin
                    mh = 0;
                    mv++;
                    if (mv == VT) begin
                        mv = 0;
                        frame++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        if ({hsync, vsync, de, rgb, snap_done} !== {e_hs, e_vs, e_de, e_rgb, e_sd}) begin
            failures++;
            $display("FAIL outputs t=%0t pos=(%0d,%0d) got hs=%b vs=%b de=%b rgb=%b sd=%b want hs=%b vs=%b de=%b rgb=%b sd=%b",
                     $time, last_h, last_v, hsync, vsync, de, rgb, snap_done, e_hs, e_vs, e_de, e_rgb, e_sd);
        end
        if (rst_n && ce_edge) begin
            if (last_h < HA && last_v < VA) pixmap[last_v][last_h] = rgb;
            if (de) de_n++;
            if (!hsync) hs_n++;
            if (!vsync) vs_n++;
        end
        if (snap_done) sd_n++;
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ce_mode)
                1:       pix_ce = 1'b1;
                2:       pix_ce = (cyc % 4) == 3;
                3:       pix_ce = 1'($urandom_range(0, 1));
                default: pix_ce = 1'b0;
            endcase
            cyc++;
        end
    end

    task automatic chk(string name, int got, int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic wait_frame(int n);
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            #1;
            if (frame >= n) begin
                ce_mode = 0;
                return;
            end
        end
        ce_mode = 0;
        chk("wait_frame_timeout", frame, n);
    endtask

    task automatic wait_pos(int h, int v);
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk);
            #1;
            if (mh == h && mv == v) return;
        end
        chk("wait_pos_timeout", mh * 1000 + mv, h * 1000 + v);
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_hsync"}, int'(hsync), 1);
        chk({tag, "_vsync"}, int'(vsync), 1);
        chk({tag, "_de"}, int'(de), 0);
        chk({tag, "_rgb"}, int'(rgb), 0);
        chk({tag, "_snap_done"}, int'(snap_done), 0);
    endtask

    function automatic int count_map_diff(logic [399:0] s);
        int bad = 0;
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++)
                if (pixmap[y][x] !== ref_rgb(x, y, s)) bad++;
        return bad;
    endfunction

    typedef struct {
        int         x;
        int         y;
        logic [2:0] exp;
    } vec_t;

    vec_t tbl [13];
    int   sd0;

    initial begin
        tbl[0]  = '{4, 4, 3'b111};
        tbl[1]  = '{5, 5, 3'b111};
        tbl[2]  = '{5, 4, 3'b111};
        tbl[3]  = '{6, 4, GRID ? 3'b010 : 3'b000};
        tbl[4]  = '{7, 5, 3'b000};
        tbl[5]  = '{4, 6, GRID ? 3'b010 : 3'b000};
        tbl[6]  = '{3, 4, 3'b001};
        tbl[7]  = '{2, 2, 3'b001};
        tbl[8]  = '{45, 45, 3'b001};
        tbl[9]  = '{44, 10, 3'b001};
        tbl[10] = '{46, 10, 3'b000};
        tbl[11] = '{1, 1, 3'b000};
        tbl[12] = '{10, 47, 3'b000};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");

        // Frame 0: single cell set before the capture point
        field_in = 400'b1;
        rst_n    = 1'b1;
        ce_mode  = 1;
        wait_frame(1);
        @(negedge clk);
        #1;
        chk("frame0_de_count", de_n, HA * VA);
        chk("frame0_hsync_low", hs_n, HS * VT);
        chk("frame0_vsync_low", vs_n, VSY * HT);
        chk("frame0_snap_pulses", sd_n, 1);

        // Frame 1 shows the captured cell
        ce_mode = 1;
        wait_frame(2);
        repeat (2) @(negedge clk);
        foreach (tbl[i]) begin
            checks++;
            if (pixmap[tbl[i].y][tbl[i].x] !== tbl[i].exp) begin
                failures++;
                $display("FAIL pixel(%0d,%0d) got=%b want=%b", tbl[i].x, tbl[i].y,
                         pixmap[tbl[i].y][tbl[i].x], tbl[i].exp);
            end
        end
        chk("frame1_map_diffs", count_map_diff(400'b1), 0);

        // Frame 2: field changes mid-active, must not tear
        sd0     = sd_n;
        ce_mode = 1;
        wait_pos(0, 20);
        field_in = '1;
        wait_frame(3);
        @(negedge clk);
        #1;
        chk("no_tear_empty_cell", int'(pixmap[40][8]), GRID ? 2 : 0);
        chk("no_tear_filled_cell", int'(pixmap[4][4]), 7);
        chk("no_tear_map_diffs", count_map_diff(400'b1), 0);
        chk("frame2_snap_pulses", sd_n - sd0, 1);

        // Frame 3: fully white field
        ce_mode = 1;
        wait_frame(4);
        @(negedge clk);
        #1;
        chk("white_map_diffs", count_map_diff('1), 0);

        // Frame 4: pixel enable every 4th clock
        de_n = 0;
        sd0  = sd_n;
        ce_mode = 2;
        wait_frame(5);
        @(negedge clk);
        #1;
        chk("ce4_de_count", de_n, HA * VA);
        chk("ce4_snap_pulses", sd_n - sd0, 1);
        chk("ce4_map_diffs", count_map_diff('1), 0);

        // Frames 5-6: random enable and random field updates
        ce_mode = 3;
        for (int i = 0; i < 30000 && frame < 7; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 299) == 0) field_in = rnd_field();
        end
        ce_mode = 0;
        chk("random_frames_reached", int'(frame >= 7), 1);

        // Reset mid-frame with a non-empty snapshot
        field_in = '1;
        ce_mode  = 1;
        wait_frame(frame + 1);
        ce_mode = 1;
        wait_pos(30, 20);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        repeat (3) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        ce_mode = 1;
        wait_frame(1);
        @(negedge clk);
        #1;
        chk("after_reset_cell0", int'(pixmap[4][4]), GRID ? 2 : 0);
        chk("after_reset_map_diffs", count_map_diff('0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/field_scanout.md
# field_scanout

Raster reader for the playfield. It takes the 400-bit occupancy vector that the field logic writes, captures it once per frame during vertical blanking, and scans it out as a VGA-style pixel stream with sync and 3-bit colour. It sits between the field datapath and the display pins, and is the consumer side of `field_display_out`.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal front porch / sync / back porch in pixels
- `V_ACTIVE`, 480, visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical front porch / sync / back porch in lines
- `CELL_PX`, 16, pixel edge of one cell; power of two
- `X0` / `Y0`, 160 / 80, top-left pixel of cell (row 0, col 0)
- `clk`, in, 1, system clock
- `rst_n`, in, 1, asynchronous active-low reset
- `pix_ce`, in, 1, pixel-advance enable; counters and outputs move only on `clk` edges with `pix_ce`=1
- `field_in`, in, 400, occupancy; bit `row*20+col`, row 0 = top, col 0 = left, 1 = filled
- `hsync`, out, 1, active-low horizontal sync
- `vsync`, out, 1, active-low vertical sync
- `de`, out, 1, display enable (active area)
- `rgb`, out, 3, {R,G,B} pixel colour
- `snap_done`, out, 1, one-`clk` pulse when `field_in` is captured

## Operation
- `h_cnt` runs 0..H_TOTAL-1 with H_TOTAL = sum of the H parameters (800 at defaults). `v_cnt` runs 0..V_TOTAL-1 (525 at defaults). `v_cnt` advances when `h_cnt` wraps. Both counters advance only on `pix_ce`.
- Sync regions:
  - `hsync`=0 for `h_cnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - `vsync`=0 for `v_cnt` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- `de`=1 when `h_cnt`<H_ACTIVE and `v_cnt`<V_ACTIVE.
- Snapshot: on the `pix_ce` cycle with `h_cnt`=0 and `v_cnt`=V_ACTIVE, copy `field_in` into a 400-bit `snap` register and pulse `snap_done`.
  - Changes to `field_in` at any other time have no visible effect. No tearing is allowed.
- Pixel classification, only while `de`=1:
  - Field: x in [X0, X0+20*CELL_PX) and y in [Y0, Y0+20*CELL_PX). Cell col = (x-X0)/CELL_PX and row = (y-Y0)/CELL_PX, computed by shift, with no divider. `rgb` = 3'b111 if `snap[row*20+col]`, else 3'b000.
  - Border: within CELL_PX pixels outside the field rectangle on any side, corners included. `rgb` = 3'b001.
  - Elsewhere: `rgb` = 3'b000.
- `rgb` is forced to 3'b000 whenever `de`=0.

## Timing
- Reset values: `h_cnt`=0, `v_cnt`=0, `snap`=0, `hsync`=1, `vsync`=1, `de`=0, `rgb`=0, `snap_done`=0.
- All outputs are registered. Outputs for counter position (h,v) appear after the `pix_ce` edge that advances the counters past (h,v), which is one pixel of latency. `hsync`, `vsync`, `de` and `rgb` stay aligned with each other.
- `snap_done` is high for exactly one `clk` cycle: the cycle after the capturing `pix_ce` edge. It is not stretched by `pix_ce`.
- `pix_ce`=0 holds every output and counter. `snap_done` still deasserts after one cycle.
- Wrap: (H_TOTAL-1, V_TOTAL-1) goes to (0,0) on the next `pix_ce`.
- Reset asserted mid-frame clears everything asynchronously. After release, scanning restarts at (0,0) with an empty snapshot until the next capture point.

## Configuration
- `SCAN_GRID_EN` defined: field pixels that are empty and lie on a cell's first row or first column (offset 0 within the cell) output 3'b010, drawing a green grid. Filled cells are unchanged.
- `SCAN_GRID_EN` undefined: empty field pixels are always 3'b000. No grid logic is synthesised.

## Test plan
- Reset, then `pix_ce`=1 every cycle for one frame → 800 `clk` per line, 525 lines. `hsync` low for 96 pixels starting at h=656; `vsync` low on lines 490–491; exactly 307200 `de` cycles.
- `field_in` with only bit 0 set, applied before the capture point → next frame shows `rgb`=111 for x 160..175, y 80..95. All other field pixels 000; border pixels 001 (e.g. x=150, y=200).
- `field_in` toggled to all-ones mid-active-frame → current frame unchanged. `snap_done` pulses once at (0,480), and the following frame is fully white inside the field.
- `pix_ce` asserted every 4th cycle → identical pixel sequence to test 1, each value held 4 cycles. `snap_done` stays 1 cycle wide.
- Assert `rst_n`=0 at (300,200) with the snapshot non-zero → outputs go to reset values immediately. After release, the first frame shows an empty field.
- With `SCAN_GRID_EN` and `field_in`=0 → pixel (176,80) gives 010 and (177,81) gives 000. Without the macro → both 000.
